// File: rtl/scv_pkg.sv
// Shared types for the SCV host-input path: merged HMI state, key-matrix
// row numbers and the pause FSM state encoding.
// Latency: n/a (types only). Backpressure: n/a.
package scv_pkg;

  // One controller. With this packing, bit 0 is r and bit 5 is t2.
  // That is the column order of the key matrix, so a joy_t drops
  // straight into a row.
  typedef struct packed {
    logic t2;
    logic t1;
    logic u;
    logic d;
    logic l;
    logic r;
  } joy_t;

  // Merged joystick/keyboard state from the host-input merge logic.
  typedef struct packed {
    logic       pause;
    logic       en;
    logic       cl;
    logic [9:0] num;
    joy_t       c2;
    joy_t       c1;
  } hmi_t;

  // Matrix row numbers; a row is selected by driving PA[row] low.
  localparam int KEYROW_C1   = 0;
  localparam int KEYROW_C2   = 1;
  localparam int KEYROW_NUM  = 2;
  localparam int KEYROW_MISC = 3;

  typedef enum logic [1:0] {
    IDLE,
    ASSERT,
    HOLD
  } pause_state_t;

  // Controller row: bits 0..5 = {r, l, d, u, t1, t2}, bits 6..7 unused.
  function automatic logic [7:0] joy_row(joy_t j);
    return {2'b00, j};
  endfunction

  // Misc row: bits 0..3 = {num[8], num[9], cl, en}.
  function automatic logic [7:0] misc_row(hmi_t h);
    return {4'b0000, h.en, h.cl, h.num[9], h.num[8]};
  endfunction

endpackage

// File: rtl/hmi_autofire.sv
// Autofire gate for one trigger: frame counter plus phase bit.
// Latency: phase updates on the snapshot edge. Backpressure: none.
// Ports: clk_i/rst_ni (sync, active-low); sample_i = snapshot strobe (VBL);
//   count_i = first cycle of a VBL pulse; old_i/new_i = trigger in the
//   snapshot before and after this edge; phase_o = 1 while autofire lets
//   the trigger through.
// Only built when SCV_AUTOFIRE_EN is defined. Without it the top level has
// no instance, so no module is left unused.
`ifdef SCV_AUTOFIRE_EN
module hmi_autofire #(
  parameter int FRAMES = 3
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic sample_i,
  input  logic count_i,
  input  logic old_i,
  input  logic new_i,
  output logic phase_o
);

  localparam logic [3:0] LAST = 4'(FRAMES - 1);

  logic [3:0] cnt_q;
  logic       phase_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else if (sample_i) begin
      if (!new_i) begin
        // Released: idle with the phase low.
        cnt_q   <= '0;
        phase_q <= 1'b0;
      end else if (!old_i) begin
        // A fresh press always shows as pressed in its first frame.
        cnt_q   <= '0;
        phase_q <= 1'b1;
      end else if (count_i) begin
        // Held: count frames only once per VBL pulse, even if VBL is
        // held for several cycles.
        if (cnt_q == LAST) begin
          cnt_q   <= '0;
          phase_q <= ~phase_q;
        end else begin
          cnt_q <= cnt_q + 4'd1;
        end
      end
    end
  end

  assign phase_o = phase_q;

endmodule
`endif

// File: rtl/hmi_scan.sv
// SCV key-matrix scanner: per-frame HMI snapshot, autofire, registered
// row/column read, and a one-shot pause request.
// Latency: PB 1 cycle after PA/snapshot; PAUSE_REQ 1 cycle after pause edge.
// Backpressure: none; the CPU port is read every cycle.
// Ports: CLK_SYS clock; RESB sync active-low reset; HMI_IN live input;
//   VBL frame strobe; AUTOFIRE per-trigger enables {c2.t2,c2.t1,c1.t2,c1.t1};
//   PA row select (active-low); PB column data (active-low);
//   PAUSE_REQ pause pulse.
// Optional feature: SCV_AUTOFIRE_EN compiles in the autofire gates. Without
// it, AUTOFIRE is ignored and triggers come straight from the snapshot.
module hmi_scan
  import scv_pkg::*;
#(
  parameter int AUTOFIRE_FRAMES = 3,
  parameter int PAUSE_PULSE     = 16
) (
  input  logic       CLK_SYS,
  input  logic       RESB,
  input  hmi_t       HMI_IN,
  input  logic       VBL,
  input  logic [3:0] AUTOFIRE,
  input  logic [7:0] PA,
  output logic [7:0] PB,
  output logic       PAUSE_REQ
);

  localparam logic [7:0] PULSE_LEN = 8'(PAUSE_PULSE);

  hmi_t         snap_q;
  logic [7:0]   pb_q, pb_d;
  logic [3:0]   trig_gate;
  pause_state_t pstate_q;
  logic [7:0]   pcnt_q;
  logic         pause_req_q;
  logic         pause_prev_q;
  logic         unused_pa;

  // Snapshot: the CPU only ever sees this copy, so the matrix is frame-stable.
  always_ff @(posedge CLK_SYS) begin
    if (!RESB) begin
      snap_q <= '0;
    end else if (VBL) begin
      snap_q <= HMI_IN;
    end
  end

`ifdef SCV_AUTOFIRE_EN
  logic       vbl_q;
  logic       vbl_rise;
  logic [3:0] trig_old, trig_new, phase;

  always_ff @(posedge CLK_SYS) begin
    if (!RESB) begin
      vbl_q <= 1'b0;
    end else begin
      vbl_q <= VBL;
    end
  end

  assign vbl_rise = VBL & ~vbl_q;
  assign trig_old = {snap_q.c2.t2, snap_q.c2.t1, snap_q.c1.t2, snap_q.c1.t1};
  assign trig_new = {HMI_IN.c2.t2, HMI_IN.c2.t1, HMI_IN.c1.t2, HMI_IN.c1.t1};

  for (genvar i = 0; i < 4; i++) begin : g_af
    hmi_autofire #(
      .FRAMES(AUTOFIRE_FRAMES)
    ) u_af (
      .clk_i   (CLK_SYS),
      .rst_ni  (RESB),
      .sample_i(VBL),
      .count_i (vbl_rise),
      .old_i   (trig_old[i]),
      .new_i   (trig_new[i]),
      .phase_o (phase[i])
    );
  end

  // A trigger without autofire enabled passes whenever it is held.
  assign trig_gate = phase | ~AUTOFIRE;
`else
  logic unused_af;

  assign trig_gate = 4'hF;
  assign unused_af = ^{AUTOFIRE, 4'(AUTOFIRE_FRAMES)};
`endif

  // Rows 4..7 have no keys, so their select lines are never looked at.
  assign unused_pa = ^PA[7:4];

  // Matrix read: OR the selected rows, then invert onto the active-low bus.
  always_comb begin
    joy_t       c1_eff;
    joy_t       c2_eff;
    logic [7:0] acc;

    c1_eff    = snap_q.c1;
    c2_eff    = snap_q.c2;
    c1_eff.t1 = snap_q.c1.t1 & trig_gate[0];
    c1_eff.t2 = snap_q.c1.t2 & trig_gate[1];
    c2_eff.t1 = snap_q.c2.t1 & trig_gate[2];
    c2_eff.t2 = snap_q.c2.t2 & trig_gate[3];

    acc = 8'h00;
    if (!PA[KEYROW_C1])   acc = acc | joy_row(c1_eff);
    if (!PA[KEYROW_C2])   acc = acc | joy_row(c2_eff);
    if (!PA[KEYROW_NUM])  acc = acc | snap_q.num[7:0];
    if (!PA[KEYROW_MISC]) acc = acc | misc_row(snap_q);
    pb_d = ~acc;
  end

  always_ff @(posedge CLK_SYS) begin
    if (!RESB) begin
      pb_q <= 8'hFF;
    end else begin
      pb_q <= pb_d;
    end
  end

  // Pause: one fixed-length pulse per press. HOLD blocks retriggering
  // until the key is seen released in a later snapshot.
  always_ff @(posedge CLK_SYS) begin
    if (!RESB) begin
      pstate_q     <= IDLE;
      pcnt_q       <= '0;
      pause_req_q  <= 1'b0;
      pause_prev_q <= 1'b0;
    end else begin
      pause_prev_q <= snap_q.pause;
      case (pstate_q)
        IDLE: begin
          if (snap_q.pause && !pause_prev_q) begin
            pstate_q    <= ASSERT;
            pcnt_q      <= PULSE_LEN;
            pause_req_q <= 1'b1;
          end
        end
        ASSERT: begin
          if (pcnt_q == 8'd1) begin
            pstate_q    <= HOLD;
            pause_req_q <= 1'b0;
          end else begin
            pcnt_q <= pcnt_q - 8'd1;
          end
        end
        HOLD: begin
          if (!snap_q.pause) begin
            pstate_q <= IDLE;
          end
        end
        default: begin
          pstate_q    <= IDLE;
          pause_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign PB        = pb_q;
  assign PAUSE_REQ = pause_req_q;

endmodule

// File: tb/tb_hmi_scan.sv
// Self-checking bench for hmi_scan.
// Stimulus queues expected PB/PAUSE_REQ values tagged with a cycle number.
// A monitor checks them on the falling clock edge.
module tb_hmi_scan;
  import scv_pkg::*;

  logic       clk = 1'b0;
  logic       resb;
  hmi_t       hmi;
  logic       vbl;
  logic [3:0] af;
  logic [7:0] pa;
  logic [7:0] pb;
  logic       pr;

  always #5 clk = ~clk;

  hmi_scan #(
    .AUTOFIRE_FRAMES(3),
    .PAUSE_PULSE    (16)
  ) dut (
    .CLK_SYS  (clk),
    .RESB     (resb),
    .HMI_IN   (hmi),
    .VBL      (vbl),
    .AUTOFIRE (af),
    .PA       (pa),
    .PB       (pb),
    .PAUSE_REQ(pr)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [95:0] nm;
    int          at;
    bit          is_pr;
    logic [7:0]  val;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic push(input logic [95:0] nm, input int at, input bit is_pr,
                      input logic [7:0] val);
    exp_t e;
    e.nm = nm; e.at = at; e.is_pr = is_pr; e.val = val;
    sb.push_back(e);
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic vbl_pulse();
    vbl = 1'b1;
    step();
    vbl = 1'b0;
  endtask

  // Monitor: pop every expectation that has come due and compare it.
  initial begin : monitor
    logic [7:0] act;
    forever begin
      @(negedge clk);
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].at <= cyc) begin
          act = sb[i].is_pr ? {7'b0, pr} : pb;
          n_cmp++;
          if (sb[i].at != cyc || act !== sb[i].val) begin
            n_bad++;
            $display("FAIL %0s cyc=%0d: got %02h want %02h (due cyc %0d)",
                     sb[i].nm, cyc, act, sb[i].val, sb[i].at);
          end
          sb.delete(i);
        end
      end
    end
  end

  function automatic bit af_pressed(input int f);
`ifdef SCV_AUTOFIRE_EN
    return ((f - 1) / 3) % 2 == 0;
`else
    return 1'b1;
`endif
  endfunction

  initial begin : stim
    int c0;

    // Reset with everything pressed and every row selected.
    resb = 1'b0; hmi = '1; vbl = 1'b1; af = 4'hF; pa = 8'h00;
    for (int i = 0; i < 6; i++) begin
      step();
      push("rst_pb", cyc, 1'b0, 8'hFF);
      push("rst_pr", cyc, 1'b1, 8'h00);
    end
    resb = 1'b1; vbl = 1'b0; hmi = '0; af = 4'h0; pa = 8'hFF;
    step(2);

    // Snapshot: live input is not visible until VBL.
    hmi.c1.u = 1'b1; pa = 8'hFE;
    push("snap_novbl", cyc + 1, 1'b0, 8'hFF);
    step(3);
    vbl_pulse();
    push("snap_lat", cyc, 1'b0, 8'hFF);
    push("snap_vbl", cyc + 1, 1'b0, 8'hF7);
    step();
    hmi = '0;
    push("snap_keep", cyc + 1, 1'b0, 8'hF7);
    push("snap_keep2", cyc + 3, 1'b0, 8'hF7);
    step(4);

    // Multi-row reads.
    hmi.num[0] = 1'b1; hmi.en = 1'b1;
    vbl_pulse();
    pa = 8'hF3; push("multi_f3", cyc + 1, 1'b0, 8'hF6); step();
    pa = 8'hFB; push("multi_fb", cyc + 1, 1'b0, 8'hFE); step();
    pa = 8'hFF; push("pa_ff", cyc + 1, 1'b0, 8'hFF); step();
    hmi = '0; hmi.num[9] = 1'b1; hmi.cl = 1'b1; hmi.c2.l = 1'b1;
    vbl_pulse();
    pa = 8'h00; push("all_rows", cyc + 1, 1'b0, 8'hF9); step();
    pa = 8'hFD; push("row1", cyc + 1, 1'b0, 8'hFD); step();
    pa = 8'hF7; push("row3", cyc + 1, 1'b0, 8'hF9); step();
    pa = 8'h0F; push("rows4_7", cyc + 1, 1'b0, 8'hFF); step();

    // Autofire on c1.t1, half-period 3 frames.
    hmi = '0; hmi.c1.t1 = 1'b1; af = 4'b0001; pa = 8'hFE;
    for (int f = 1; f <= 12; f++) begin
      vbl_pulse();
      push("af_0001", cyc + 1, 1'b0, af_pressed(f) ? 8'hEF : 8'hFF);
      push("af_stable", cyc + 3, 1'b0, af_pressed(f) ? 8'hEF : 8'hFF);
      step(3);
    end
    hmi.c1.t1 = 1'b0;
    vbl_pulse();
    push("af_rel", cyc + 1, 1'b0, 8'hFF);
    step(3);

    // Autofire disabled: pressed every frame.
    hmi.c1.t1 = 1'b1; af = 4'b0000;
    for (int f = 1; f <= 12; f++) begin
      vbl_pulse();
      push("af_off", cyc + 1, 1'b0, 8'hEF);
      step(3);
    end

    // Pause held 5 frames: one 16-cycle pulse, with VBL arriving mid-pulse.
    hmi = '0; pa = 8'hFF; hmi.pause = 1'b1;
    c0 = cyc;
    for (int d = 1; d <= 50; d++)
      push("pause1", c0 + d, 1'b1, (d >= 2 && d <= 17) ? 8'h01 : 8'h00);
    repeat (5) begin
      vbl_pulse();
      step(9);
    end

    hmi.pause = 1'b0;
    c0 = cyc;
    for (int d = 1; d <= 10; d++) push("pause_rel", c0 + d, 1'b1, 8'h00);
    vbl_pulse();
    step(9);

    // Second press gives a second pulse.
    hmi.pause = 1'b1;
    c0 = cyc;
    for (int d = 1; d <= 40; d++)
      push("pause2", c0 + d, 1'b1, (d >= 2 && d <= 17) ? 8'h01 : 8'h00);
    vbl_pulse();
    step(39);

    hmi.pause = 1'b0;
    c0 = cyc;
    for (int d = 1; d <= 10; d++) push("pause_rel2", c0 + d, 1'b1, 8'h00);
    vbl_pulse();
    step(9);

    // Reset at pulse cycle 8 aborts the pulse on the next edge.
    hmi.pause = 1'b1;
    c0 = cyc;
    for (int d = 1; d <= 9; d++)
      push("pause3", c0 + d, 1'b1, (d >= 2) ? 8'h01 : 8'h00);
    vbl_pulse();
    step(8);
    resb = 1'b0;
    push("rst_mid_pr", c0 + 10, 1'b1, 8'h00);
    push("rst_mid_pr2", c0 + 12, 1'b1, 8'h00);
    push("rst_mid_pb", c0 + 10, 1'b0, 8'hFF);
    step(3);
    resb = 1'b1;
    step(2);

    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      n_cmp += sb.size();
      n_bad += sb.size();
      $display("FAIL leftover: got %0d unchecked expectations, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
